// File: rtl/scratchpad_store_sched_if.sv
// Store request / scratchpad write bundle between the lane store path and the scheduler.
interface scratchpad_store_sched_if #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PASS_W     = $clog2(LANES) + 1
);
    logic                                  req_valid;
    logic                                  req_ready;
    logic [LANES-1:0]                      req_mask;
    logic [LANES-1:0][ADDR_WIDTH-1:0]      req_addr;
    logic [LANES-1:0][DATA_WIDTH-1:0]      req_data;
    logic [LANES-1:0]                      write_en;
    logic [LANES-1:0][ADDR_WIDTH-1:0]      write_addr;
    logic [LANES-1:0][DATA_WIDTH-1:0]      write_data;
    logic                                  done;
    logic [PASS_W-1:0]                     passes;

    // Requester side: drives the store request, observes writes and completion.
    modport master (
        output req_valid, req_mask, req_addr, req_data,
        input  req_ready, write_en, write_addr, write_data, done, passes
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_mask, req_addr, req_data,
        output req_ready, write_en, write_addr, write_data, done, passes
    );
endinterface

// File: rtl/scratchpad_store_sched.sv
// Splits a warp-wide masked store into conflict-free write passes. Lanes sharing an
// address issue in ascending lane order, so the highest lane's data lands last.
module scratchpad_store_sched #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PASS_W     = $clog2(LANES) + 1
) (
    input logic                     clk,
    input logic                     rst,
    scratchpad_store_sched_if.slave bus
);
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic [0:0] {StIdle, StIssue} state_t;

    state_t                           state;
    logic [LANES-1:0]                 pending;
    logic [LANES-1:0][ADDR_WIDTH-1:0] addr_q;
    word_t [LANES-1:0]                data_q;
    logic [PASS_W-1:0]                pass_cnt;
    logic [PASS_W-1:0]                passes_q;

    logic [LANES-1:0]                 grant;
    logic [LANES-1:0]                 remaining;

    // A pending lane is granted unless a lower pending lane targets the same address.
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            grant[i] = pending[i];
            for (int unsigned j = 0; j < i; j++) begin
                if (pending[j] && (addr_q[j] == addr_q[i])) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    assign remaining = pending & ~grant;

    // Outputs derived from registered state only.
    always_comb begin
        bus.req_ready  = (state == StIdle);
        bus.write_en   = (state == StIssue) ? grant : '0;
        bus.write_addr = addr_q;
        bus.write_data = data_q;
        bus.done       = (state == StIssue) && (remaining == '0);
        bus.passes     = passes_q;
    end

    // Request latch, pass bookkeeping and IDLE/ISSUE sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            pending  <= '0;
            pass_cnt <= '0;
            passes_q <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        pending  <= bus.req_mask;
                        addr_q   <= bus.req_addr;
                        data_q   <= bus.req_data;
                        pass_cnt <= '0;
                        state    <= StIssue;
                    end
                end
                StIssue: begin
                    pending  <= remaining;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                    if (remaining == '0) begin
                        // An empty mask still spends one ISSUE cycle but reports zero passes.
                        passes_q <= (pending == '0) ? '0 : pass_cnt + PASS_W'(1);
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/scratchpad_store_sched.md
Name: scratchpad_store_sched

Overview:
- Store scheduler that sits between the shader lane store path and the per-lane-write scratchpad.
- Accepts one warp-wide store request with a per-lane mask, addresses and data, then issues it over one or more write passes.
- Each pass contains no two enabled lanes with the same address.
- Final memory contents equal in-order lane semantics: the higher lane index wins on a collision.

Parameters:
- LANES, default lanes (package constant): number of lanes.
- ADDR_WIDTH, default $clog2(MEM_DEPTH): scratchpad address width.
- PASS_W, default $clog2(LANES)+1: width of the pass counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  scheduler can accept a request.
- req_mask  in  LANES  per-lane store enable.
- req_addr  in  ADDR_WIDTH x LANES  per-lane address.
- req_data  in  word_t x LANES  per-lane data.
- write_en  out  LANES  to scratchpad write_en.
- write_addr  out  ADDR_WIDTH x LANES  to scratchpad write_addr.
- write_data  out  word_t x LANES  to scratchpad write_data.
- done  out  1  one-cycle pulse: request fully written.
- passes  out  PASS_W  number of write passes used by the last completed request.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- States: IDLE and ISSUE.
- Reset (any state, including mid-ISSUE):
  - state=IDLE, pending=0, pass_cnt=0, passes=0, done=0, write_en=0.
  - Remaining unissued writes are dropped.
  - Latched addr/data need not be cleared.
- IDLE:
  - req_ready=1, write_en=0.
  - On req_valid&&req_ready: latch mask into pending, latch addr/data, pass_cnt=0, go to ISSUE.
- ISSUE:
  - req_ready=0; req_valid is ignored.
  - grant[i] = pending[i] AND no j<i with pending[j] && addr[j]==addr[i].
  - write_en=grant (combinational from registered state). write_addr/write_data are the latched values for all lanes.
  - At the clock edge: pending &= ~grant, pass_cnt++.
  - When (pending & ~grant)==0: done=1 in the same cycle as the last pass, passes<=pass_cnt+1, next state IDLE.
- Ordering: lower-index lanes to an address always write in an earlier pass than higher-index lanes to that address, so the highest-index lane's data is final.
- Lanes with distinct addresses all issue in pass 1.
- Pass count = max over addresses of the number of masked lanes sharing that address. Range is 1..LANES.
- Empty mask (req_mask=0):
  - Request is accepted and ISSUE lasts one cycle with write_en=0.
  - done=1, passes<=0.
- Latency:
  - Accept at edge N; first pass is visible in cycle N+1; done coincides with the final pass.
  - Next accept is possible at the edge after done (one IDLE cycle).
- done is never asserted outside ISSUE.
- passes holds its value until the next completion or reset.
- Unmasked lanes never assert write_en.

Test Plan:
- Reset: assert rst with a request pending in ISSUE for 1 cycle -> write_en=0, req_ready=1, done=0, passes=0 next cycle; no further writes.
- No conflict, LANES=4: mask=4'b1111, addr={3,2,1,0}, data={D,C,B,A} -> one cycle write_en=1111 with done=1, passes=1; mem[0..3]=A,B,C,D.
- Full conflict: mask=1111, all addr=5, data lane i = 0x10+i -> four cycles write_en=0001,0010,0100,1000; done on the 4th; passes=4; mem[5]=0x13.
- Partial conflict: mask=1011, addr={7,9,7,7} (lane3..0) -> pass1 write_en=0001, pass2 0010, pass3 1000; lane2 never enabled; passes=3; mem[7]=lane3 data.
- Empty mask: req_mask=0 -> one ISSUE cycle with write_en=0, done=1, passes=0.
- Back-to-back: hold req_valid high with two requests -> second is accepted exactly one cycle after the first done; req_ready=0 throughout ISSUE; no writes are lost.
